// File: rtl/boot_pkg.sv
// ---------------------------------------------------------------------------
// boot_pkg
// Shared types and constants for the UART boot-load word packer.
//   boot_state_e  : loader state machine encoding
//   boot_err_e    : sticky error code reported on err_code_o
//   SYNC_BYTE_DEF : default data-frame start marker
//   GO_BYTE_DEF   : default release-core command byte
// ---------------------------------------------------------------------------
package boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_ERR,
        ST_DRAIN,
        ST_DONE
    } boot_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_CSUM     = 2'd1,
        ERR_OVERFLOW = 2'd2,
        ERR_BAD_BYTE = 2'd3
    } boot_err_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam logic [7:0] GO_BYTE_DEF   = 8'h5A;

endpackage

// File: rtl/boot_wr_fifo.sv
// ---------------------------------------------------------------------------
// boot_wr_fifo
// Two-entry FIFO buffering packed {address, data} words in front of the
// ICCM write port. The head entry lives in its own register so the write
// port is driven straight from flops.
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset
//   push_i        : write push_data_i into the FIFO
//   push_data_i   : W-bit payload
//   pop_i         : head entry consumed this cycle (caller gates with valid)
//   head_data_o   : current head payload (RESET_HEAD after reset)
//   head_valid_o  : head entry present
//   full_o        : both entries occupied
//   empty_o       : no entries occupied
// A push while full is dropped unless a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module boot_wr_fifo #(
    parameter int             W          = 44,
    parameter logic [W-1:0]   RESET_HEAD = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_data_o,
    output logic         head_valid_o,
    output logic         full_o,
    output logic         empty_o
);

    logic [W-1:0] head_data_q;
    logic [W-1:0] tail_data_q;
    logic         head_valid_q;
    logic         tail_valid_q;

    // Occupancy is tracked as head/tail valid bits. Data always moves from
    // tail to head on a pop, so the head register is the only one the write
    // port ever sees. A push that meets a full FIFO with no pop is dropped;
    // the top level flags that case as an overflow.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_data_q  <= RESET_HEAD;
            tail_data_q  <= '0;
            head_valid_q <= 1'b0;
            tail_valid_q <= 1'b0;
        end else begin
            case ({head_valid_q, tail_valid_q})
                2'b00: begin
                    if (push_i) begin
                        head_data_q  <= push_data_i;
                        head_valid_q <= 1'b1;
                    end
                end
                2'b10: begin
                    if (push_i && pop_i) begin
                        head_data_q <= push_data_i;
                    end else if (push_i) begin
                        tail_data_q  <= push_data_i;
                        tail_valid_q <= 1'b1;
                    end else if (pop_i) begin
                        head_valid_q <= 1'b0;
                    end
                end
                2'b11: begin
                    if (pop_i) begin
                        head_data_q <= tail_data_q;
                        if (push_i) begin
                            tail_data_q <= push_data_i;
                        end else begin
                            tail_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    head_valid_q <= 1'b0;
                    tail_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign head_data_o  = head_data_q;
    assign head_valid_o = head_valid_q;
    assign full_o       = tail_valid_q;
    assign empty_o      = !head_valid_q;

endmodule

// File: rtl/boot_word_packer.sv
// ---------------------------------------------------------------------------
// boot_word_packer
// UART boot-load stage. Parses the framed byte stream from the UART
// receiver, packs little-endian bytes into 32-bit words and writes them to
// the ICCM through a valid/ready port buffered by a 2-entry FIFO. Holds the
// core in reset until the host sends the GO byte and all writes drained.
// Frame: SyncByte, CNT (words, 0 = 256), 4*CNT data bytes LSB first,
// and a trailing checksum byte when BOOT_WORD_PACKER_CSUM_EN is defined.
// Ports:
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   rx_dv_i, rx_byte_i     : received byte strobe and value
//   wr_valid_o, wr_ready_i : ICCM word write handshake
//   wr_addr_o, wr_data_o   : word address / data of the write at the head
//   boot_hold_o            : 1 keeps the core in reset
//   done_o                 : GO accepted and all writes drained
//   err_o, err_code_o      : sticky frame error and its cause
// Build option: define BOOT_WORD_PACKER_CSUM_EN to expect and check the
// per-frame checksum byte.
// ---------------------------------------------------------------------------
module boot_word_packer
    import boot_pkg::*;
#(
    parameter int               AddrW    = 12,
    parameter logic [AddrW-1:0] BaseAddr = '0,
    parameter logic [7:0]       SyncByte = SYNC_BYTE_DEF,
    parameter logic [7:0]       GoByte   = GO_BYTE_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             rx_dv_i,
    input  logic [7:0]       rx_byte_i,
    output logic             wr_valid_o,
    input  logic             wr_ready_i,
    output logic [AddrW-1:0] wr_addr_o,
    output logic [31:0]      wr_data_o,
    output logic             boot_hold_o,
    output logic             done_o,
    output logic             err_o,
    output logic [1:0]       err_code_o
);

    boot_state_e      state_q, state_d;
    logic [AddrW-1:0] next_addr_q;
    logic [AddrW-1:0] frame_start_q;
    logic [8:0]       words_left_q;
    logic [1:0]       byte_idx_q;
    logic [23:0]      shift_q;
    logic             err_q;
    boot_err_e        err_code_q;
    logic             done_q;
    logic             hold_q;

    logic             push;
    logic             pop;
    logic             overflow;
    logic             word_done;
    logic             last_word;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_valid;
    logic [AddrW+31:0] fifo_head;

`ifdef BOOT_WORD_PACKER_CSUM_EN
    logic [7:0]       sum_q;
    logic [7:0]       csum_total;

    assign csum_total = sum_q + rx_byte_i;
`endif

    assign word_done = (byte_idx_q == 2'd3);
    assign last_word = (words_left_q == 9'd1);
    assign pop       = fifo_valid && wr_ready_i;
    assign overflow  = push && fifo_full && !pop;

    boot_wr_fifo #(
        .W          (AddrW + 32),
        .RESET_HEAD ({BaseAddr, 32'h0})
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (push),
        .push_data_i  ({next_addr_q, rx_byte_i, shift_q}),
        .pop_i        (pop),
        .head_data_o  (fifo_head),
        .head_valid_o (fifo_valid),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    // State register for the frame parser.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and the FIFO push strobe. Byte-consuming states only
    // move on rx_dv_i. The fourth byte of each word pushes the packed word;
    // a push that overflows the FIFO overrides whatever the parser wanted.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_dv_i) begin
                    if (rx_byte_i == SyncByte) begin
                        state_d = ST_LEN;
                    end else if (rx_byte_i == GoByte) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_LEN: begin
                if (rx_dv_i) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_dv_i && word_done) begin
                    push = 1'b1;
                    if (last_word) begin
`ifdef BOOT_WORD_PACKER_CSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
            end
`ifdef BOOT_WORD_PACKER_CSUM_EN
            ST_CSUM: begin
                if (rx_dv_i) begin
                    state_d = (csum_total == 8'd0) ? ST_IDLE : ST_ERR;
                end
            end
`endif
            ST_ERR: begin
                if (rx_dv_i && (rx_byte_i == SyncByte)) begin
                    state_d = ST_LEN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty && !wr_valid_o) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (overflow) begin
            state_d = ST_ERR;
        end
    end

    // Datapath: address bookkeeping, byte packing, word counting and the
    // sticky error/status flags. A resync from ERR rewinds the address to
    // the start of the failed frame so the retransmit overwrites it.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            next_addr_q   <= BaseAddr;
            frame_start_q <= BaseAddr;
            words_left_q  <= '0;
            byte_idx_q    <= '0;
            shift_q       <= '0;
            err_q         <= 1'b0;
            err_code_q    <= ERR_NONE;
            done_q        <= 1'b0;
            hold_q        <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_dv_i) begin
                        if (rx_byte_i == SyncByte) begin
                            frame_start_q <= next_addr_q;
                        end else if (rx_byte_i != GoByte) begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_BAD_BYTE;
                        end
                    end
                end
                ST_LEN: begin
                    if (rx_dv_i) begin
                        words_left_q <= {rx_byte_i == 8'd0, rx_byte_i};
                        byte_idx_q   <= '0;
                    end
                end
                ST_DATA: begin
                    if (rx_dv_i) begin
                        shift_q    <= {rx_byte_i, shift_q[23:8]};
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (word_done) begin
                            next_addr_q  <= next_addr_q + 1'b1;
                            words_left_q <= words_left_q - 9'd1;
`ifndef BOOT_WORD_PACKER_CSUM_EN
                            if (last_word) begin
                                err_q      <= 1'b0;
                                err_code_q <= ERR_NONE;
                            end
`endif
                        end
                    end
                end
`ifdef BOOT_WORD_PACKER_CSUM_EN
                ST_CSUM: begin
                    if (rx_dv_i) begin
                        if (csum_total == 8'd0) begin
                            err_q      <= 1'b0;
                            err_code_q <= ERR_NONE;
                        end else begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_CSUM;
                        end
                    end
                end
`endif
                ST_ERR: begin
                    if (rx_dv_i && (rx_byte_i == SyncByte)) begin
                        next_addr_q <= frame_start_q;
                    end
                end
                default: begin
                end
            endcase
            if (overflow) begin
                err_q      <= 1'b1;
                err_code_q <= ERR_OVERFLOW;
            end
            if (state_d == ST_DONE) begin
                done_q <= 1'b1;
                hold_q <= 1'b0;
            end
        end
    end

`ifdef BOOT_WORD_PACKER_CSUM_EN
    // Running frame checksum: seeded with CNT, then every data byte added
    // modulo 256. The checksum byte must bring the total to zero.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sum_q <= '0;
        end else if (rx_dv_i) begin
            if (state_q == ST_LEN) begin
                sum_q <= rx_byte_i;
            end else if (state_q == ST_DATA) begin
                sum_q <= sum_q + rx_byte_i;
            end
        end
    end
`endif

    assign wr_valid_o  = fifo_valid;
    assign wr_addr_o   = fifo_head[AddrW+31:32];
    assign wr_data_o   = fifo_head[31:0];
    assign boot_hold_o = hold_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign err_code_o  = err_code_q;

endmodule

// File: tb/tb_boot_word_packer.sv
// ---------------------------------------------------------------------------
// tb_boot_word_packer
// Directed bench for boot_word_packer: framing, packing, back-pressure,
// overflow and retransmit, GO/drain, reset mid-frame and address wrap.
// Frames carry a checksum byte only when BOOT_WORD_PACKER_CSUM_EN is set.
// ---------------------------------------------------------------------------
module tb_boot_word_packer;

    logic        clk;
    logic        rst_n;
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic        wr_valid;
    logic        wr_ready;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic        boot_hold;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    int          vectorCount = 0;
    int          missCount   = 0;
    logic [11:0] capAddr[$];
    logic [31:0] capData[$];
    logic [31:0] frameWords[256];

`ifdef BOOT_WORD_PACKER_CSUM_EN
    localparam logic [11:0] GO_ADDR = 12'h007;
`else
    localparam logic [11:0] GO_ADDR = 12'h006;
`endif

    boot_word_packer dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rx_dv_i     (rx_dv),
        .rx_byte_i   (rx_byte),
        .wr_valid_o  (wr_valid),
        .wr_ready_i  (wr_ready),
        .wr_addr_o   (wr_addr),
        .wr_data_o   (wr_data),
        .boot_hold_o (boot_hold),
        .done_o      (done),
        .err_o       (err),
        .err_code_o  (err_code)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record every accepted write. Inputs change on the falling edge, so
    // valid && ready seen shortly after it is what the next rising edge takes.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && wr_valid && wr_ready) begin
            capAddr.push_back(wr_addr);
            capData.push_back(wr_data);
        end
    end

    // Absolute time limit so a stuck design can never hang the run.
    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [11:0] capA(input int k);
        capA = (k < capAddr.size()) ? capAddr[k] : 12'hxxx;
    endfunction

    function automatic logic [31:0] capD(input int k);
        capD = (k < capData.size()) ? capData[k] : 32'hxxxxxxxx;
    endfunction

    function automatic logic [31:0] patternWord(input int idx);
        logic [7:0] t;
        t = idx[7:0];
        patternWord = {t ^ 8'h5C, t, ~t, t + 8'd1};
    endfunction

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv   = 1'b0;
    endtask

    task automatic sendFrame(input int nWords, input logic [7:0] csumDelta);
        logic [7:0]  sum;
        logic [31:0] w;
        logic [7:0]  cnt;
        cnt = nWords[7:0];
        sum = cnt;
        applyStimulus(8'hA5);
        applyStimulus(cnt);
        for (int i = 0; i < nWords; i++) begin
            w = frameWords[i];
            for (int j = 0; j < 4; j++) begin
                applyStimulus(w[7:0]);
                sum = sum + w[7:0];
                w   = w >> 8;
            end
        end
`ifdef BOOT_WORD_PACKER_CSUM_EN
        applyStimulus((8'h00 - sum) + csumDelta);
`else
        sum = sum + csumDelta;
`endif
    endtask

    task automatic waitCaptures(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && capAddr.size() < n; i++) begin
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        checkOutput(tag, capAddr.size(), n);
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst_n   = 1'b0;
        rx_dv   = 1'b1;
        rx_byte = 8'h77;
        @(negedge clk);
        rx_dv   = 1'b0;
        rst_n   = 1'b1;
        capAddr.delete();
        capData.delete();
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " wr_valid"}, wr_valid, 1'b0);
        checkOutput({tag, " wr_addr"}, wr_addr, 12'h000);
        checkOutput({tag, " wr_data"}, wr_data, 32'h0);
        checkOutput({tag, " boot_hold"}, boot_hold, 1'b1);
        checkOutput({tag, " done"}, done, 1'b0);
        checkOutput({tag, " err"}, err, 1'b0);
        checkOutput({tag, " err_code"}, err_code, 2'd0);
    endtask

    initial begin
        int stable;
        int lat;
        rst_n    = 1'b0;
        rx_dv    = 1'b0;
        rx_byte  = 8'h00;
        wr_ready = 1'b1;
        repeat (2) @(negedge clk);
        applyReset();
        checkResetValues("reset");

        $display("[TB] single word frame");
        frameWords[0] = 32'h44332211;
        sendFrame(1, 8'h00);
        waitCaptures("frameA count", 1, 20);
        checkOutput("frameA addr", capA(0), 12'h000);
        checkOutput("frameA data", capD(0), 32'h44332211);
        checkOutput("frameA err", err, 1'b0);

        $display("[TB] two word frame under back-pressure");
        capAddr.delete(); capData.delete();
        wr_ready      = 1'b0;
        frameWords[0] = 32'h88776655;
        frameWords[1] = 32'hCCBBAA99;
        sendFrame(2, 8'h00);
        stable = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (wr_valid && wr_addr == 12'h001 && wr_data == 32'h88776655) stable++;
        end
        checkOutput("stall held", stable, 40);
        checkOutput("stall no overflow", err, 1'b0);
        wr_ready = 1'b1;
        waitCaptures("frameB count", 2, 20);
        checkOutput("frameB addr0", capA(0), 12'h001);
        checkOutput("frameB data0", capD(0), 32'h88776655);
        checkOutput("frameB addr1", capA(1), 12'h002);
        checkOutput("frameB data1", capD(1), 32'hCCBBAA99);

        $display("[TB] FIFO overflow and retransmit");
        capAddr.delete(); capData.delete();
        wr_ready      = 1'b0;
        frameWords[0] = 32'h13121110;
        frameWords[1] = 32'h17161514;
        frameWords[2] = 32'h1B1A1918;
        sendFrame(3, 8'h00);
        checkOutput("overflow err", err, 1'b1);
        checkOutput("overflow code", err_code, 2'd2);
        wr_ready = 1'b1;
        waitCaptures("overflow drain count", 2, 20);
        checkOutput("overflow addr0", capA(0), 12'h003);
        checkOutput("overflow data1", capD(1), 32'h17161514);
        capAddr.delete(); capData.delete();
        sendFrame(3, 8'h00);
        waitCaptures("resend count", 3, 20);
        checkOutput("resend addr0", capA(0), 12'h003);
        checkOutput("resend addr2", capA(2), 12'h005);
        checkOutput("resend data2", capD(2), 32'h1B1A1918);
        checkOutput("resend err cleared", err, 1'b0);
        checkOutput("resend code cleared", err_code, 2'd0);

`ifdef BOOT_WORD_PACKER_CSUM_EN
        $display("[TB] checksum error and retransmit");
        capAddr.delete(); capData.delete();
        frameWords[0] = 32'h01020304;
        sendFrame(1, 8'h01);
        checkOutput("csum err", err, 1'b1);
        checkOutput("csum code", err_code, 2'd1);
        sendFrame(1, 8'h00);
        waitCaptures("csum resend count", 2, 20);
        checkOutput("csum first addr", capA(0), 12'h006);
        checkOutput("csum resend addr", capA(1), 12'h006);
        checkOutput("csum resend data", capD(1), 32'h01020304);
        checkOutput("csum err cleared", err, 1'b0);
`endif

        $display("[TB] GO with pending write");
        capAddr.delete(); capData.delete();
        wr_ready      = 1'b0;
        frameWords[0] = 32'hA0B0C0D0;
        sendFrame(1, 8'h00);
        applyStimulus(8'h5A);
        repeat (10) @(negedge clk);
        checkOutput("go pending hold", boot_hold, 1'b1);
        checkOutput("go pending done", done, 1'b0);
        checkOutput("go pending valid", wr_valid, 1'b1);
        wr_ready = 1'b1;
        lat = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("go done latency ok", (lat >= 1 && lat <= 2), 1'b1);
        checkOutput("go done", done, 1'b1);
        checkOutput("go hold released", boot_hold, 1'b0);
        checkOutput("go fifo empty", wr_valid, 1'b0);
        checkOutput("go write count", capAddr.size(), 1);
        checkOutput("go write addr", capA(0), GO_ADDR);
        checkOutput("go write data", capD(0), 32'hA0B0C0D0);
        frameWords[0] = 32'h55555555;
        sendFrame(1, 8'h00);
        repeat (3) @(negedge clk);
        checkOutput("done ignores bytes", capAddr.size() + {31'd0, wr_valid}, 1);
        checkOutput("done sticky", done, 1'b1);

        $display("[TB] bad byte and reset mid-frame");
        applyReset();
        checkResetValues("reset after done");
        applyStimulus(8'h77);
        checkOutput("bad byte err", err, 1'b1);
        checkOutput("bad byte code", err_code, 2'd3);
        applyStimulus(8'hA5);
        applyStimulus(8'h02);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        applyReset();
        checkResetValues("reset mid data");
        frameWords[0] = 32'hCAFEF00D;
        sendFrame(1, 8'h00);
        waitCaptures("post reset count", 1, 20);
        checkOutput("post reset addr", capA(0), 12'h000);
        checkOutput("post reset data", capD(0), 32'hCAFEF00D);

        $display("[TB] advancing to 0xF9B then 256-word wrap frame");
        capAddr.delete(); capData.delete();
        for (int k = 0; k < 256; k++) frameWords[k] = patternWord(k);
        for (int f = 0; f < 15; f++) sendFrame(256, 8'h00);
        sendFrame(154, 8'h00);
        waitCaptures("bulk count", 3994, 50);
        checkOutput("bulk last addr", capA(3993), 12'hF9A);
        checkOutput("bulk err", err, 1'b0);
        capAddr.delete(); capData.delete();
        sendFrame(256, 8'h00);
        waitCaptures("wrap count", 256, 50);
        for (int k = 0; k < 256; k++) begin
            logic [11:0] ea;
            ea = 12'hF9B + k[11:0];
            checkOutput($sformatf("wrap addr %0d", k), capA(k), ea);
            checkOutput($sformatf("wrap data %0d", k), capD(k), patternWord(k));
        end
        checkOutput("wrap err", err, 1'b0);
        checkOutput("wrap code", err_code, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
